// File: rtl/pool_pkg.sv
// Shared types and elaboration-time helpers for the pooling block.
package pool_pkg;

  typedef enum logic [1:0] {
    POOL_ABS_AVG = 2'd0,
    POOL_ABS_MAX = 2'd1,
    POOL_AVG     = 2'd2
  } pool_mode_e;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    DONE  = 2'd2,
    PEND  = 2'd3
  } state_e;

  // round(2^n_size / input_size), half rounds up
  function automatic int recip(input int input_size, input int n_size);
    return ((1 << n_size) + input_size / 2) / input_size;
  endfunction

  // clamp a wide signed value to the signed word_size range
  function automatic logic signed [63:0] sat_word(input logic signed [63:0] value,
                                                  input int word_size);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (word_size - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (word_size - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pool_layer_channel.sv
// Single-channel datapath: optional saturating abs, accumulate or running max,
// then scale by a constant reciprocal into the result register.
module pool_channel
  import pool_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int N_SIZE     = 12,
  parameter int INPUT_SIZE = 113,
  parameter int MODE       = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 acc_en_i,
  input  logic                 scale_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] data_o
);

  localparam int ACC_W  = WORD_SIZE + $clog2(INPUT_SIZE) + 1;
  localparam int PROD_W = ACC_W + N_SIZE + 1;
  localparam pool_mode_e MODE_E = pool_mode_e'(MODE);
  localparam int RECIP = recip(INPUT_SIZE, N_SIZE);
  localparam logic signed [N_SIZE:0] RECIP_S = RECIP[N_SIZE:0];
  localparam logic signed [WORD_SIZE-1:0] W_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [WORD_SIZE-1:0] W_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] HALF =
    {{(PROD_W-N_SIZE){1'b0}}, 1'b1, {(N_SIZE-1){1'b0}}};

  logic signed [WORD_SIZE-1:0] x, x_pre;
  logic signed [ACC_W-1:0]     x_ext, acc_q, acc_d;
  logic signed [PROD_W-1:0]    prod, rounded;
  logic [WORD_SIZE-1:0]        result_q, result_d;

  // preprocess: abs with the most negative code saturating to max positive
  always_comb begin
    x     = data_i;
    x_pre = x;
    if (MODE_E != POOL_AVG) begin
      if (x == W_MIN)            x_pre = W_MAX;
      else if (x[WORD_SIZE-1])   x_pre = -x;
    end
    x_ext = ACC_W'(x_pre);
  end

  // accumulate or track the running max; cleared while the result is taken
  always_comb begin
    acc_d = acc_q;
    if (scale_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      if (MODE_E == POOL_ABS_MAX) acc_d = (x_ext > acc_q) ? x_ext : acc_q;
      else                        acc_d = acc_q + x_ext;
    end
  end

  // scale by the reciprocal at full product width, round, saturate
  always_comb begin
    prod     = PROD_W'(acc_q) * PROD_W'(RECIP_S);
    rounded  = prod + HALF;
    result_d = result_q;
    if (scale_i) begin
      if (MODE_E == POOL_ABS_MAX) result_d = acc_q[WORD_SIZE-1:0];
      else result_d = WORD_SIZE'(sat_word(64'(rounded >>> N_SIZE), WORD_SIZE));
    end
  end

  // accumulator and result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign data_o = result_q;

endmodule

// File: rtl/pool_layer.sv
// Pools N_CHANNELS conv outputs over INPUT_SIZE beats into one vector.
// Optional build macro POOL_DOUBLE_BUFFER_EN lets the next frame accumulate
// while the previous result waits for the consumer.
//
// state | meaning
// ACCUM | accepting input beats, counting towards the frame end
// SCALE | one cycle: result registers load, accumulators clear
// DONE  | result presented, waiting for yumi_i (single-buffer build)
// PEND  | frame complete but previous result unconsumed (double-buffer build)
module pool_layer
  import pool_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int N_SIZE     = 12,
  parameter int N_CHANNELS = 256,
  parameter int INPUT_SIZE = 113,
  parameter int MODE       = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [N_CHANNELS*WORD_SIZE-1:0] data_i,
  output logic                            valid_o,
  input  logic                            yumi_i,
  output logic [N_CHANNELS*WORD_SIZE-1:0] data_o
);

  localparam int CNT_W = $clog2(INPUT_SIZE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(INPUT_SIZE - 1);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_n;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             acc_en, scale;
`ifdef POOL_DOUBLE_BUFFER_EN
  logic             res_valid_q, res_valid_d;
`endif

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  // reset synchronizer: asserts immediately, releases on the clock
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= rst_sync_d;
  end

  // next-state, beat counter and handshake outputs
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ready_o = 1'b0;
    scale   = 1'b0;
`ifdef POOL_DOUBLE_BUFFER_EN
    valid_o     = res_valid_q;
    res_valid_d = res_valid_q;
    if (yumi_i) res_valid_d = 1'b0;
`else
    valid_o = 1'b0;
`endif
    case (state_q)
      ACCUM: begin
        ready_o = rst_n;
        if (valid_i && rst_n) begin
          if (count_q == LAST_BEAT) begin
            count_d = '0;
`ifdef POOL_DOUBLE_BUFFER_EN
            state_d = (res_valid_q && !yumi_i) ? PEND : SCALE;
`else
            state_d = SCALE;
`endif
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      SCALE: begin
        scale = 1'b1;
`ifdef POOL_DOUBLE_BUFFER_EN
        res_valid_d = 1'b1;
        state_d     = ACCUM;
`else
        state_d = DONE;
`endif
      end
      DONE: begin
`ifdef POOL_DOUBLE_BUFFER_EN
        state_d = ACCUM;
`else
        valid_o = 1'b1;
        if (yumi_i) state_d = ACCUM;
`endif
      end
      PEND: begin
`ifdef POOL_DOUBLE_BUFFER_EN
        if (yumi_i) state_d = SCALE;
`else
        state_d = ACCUM;
`endif
      end
      default: state_d = ACCUM;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      count_q     <= '0;
`ifdef POOL_DOUBLE_BUFFER_EN
      res_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
`ifdef POOL_DOUBLE_BUFFER_EN
      res_valid_q <= res_valid_d;
`endif
    end
  end

  assign acc_en = valid_i & ready_o;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    pool_channel #(
      .WORD_SIZE (WORD_SIZE),
      .N_SIZE    (N_SIZE),
      .INPUT_SIZE(INPUT_SIZE),
      .MODE      (MODE)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n),
      .acc_en_i(acc_en),
      .scale_i (scale),
      .data_i  (data_i[c*WORD_SIZE +: WORD_SIZE]),
      .data_o  (data_o[c*WORD_SIZE +: WORD_SIZE])
    );
  end

endmodule

// File: tb/tb_pool_layer.sv
// Bench for pool_layer: one instance per MODE sharing stimulus, checked
// against an arithmetic reference model and an expected-result queue.
`timescale 1ns/1ps
module tb_pool_layer;

  localparam int W  = 16;
  localparam int NS = 12;
  localparam int NC = 2;
  localparam int IS = 4;
  localparam int RECIP_M = $rtoi((2.0 ** NS) / IS + 0.5);
`ifdef POOL_DOUBLE_BUFFER_EN
  localparam int PERIOD = IS + 1;
  localparam logic BP_READY = 1'b1;
`else
  localparam int PERIOD = IS + 2;
  localparam logic BP_READY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic yumi_en = 1'b0;
  logic rand_yumi = 1'b0;
  logic rand_gap = 1'b0;
  logic [NC*W-1:0] data = '0;
  logic yumi;
  logic [2:0] ready_m, valid_m;
  logic [NC*W-1:0] dout_m [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t_xfer = 0;
  logic [95:0] exp_q [$];
  int rise_q [$];
  logic [15:0] f0 [IS];
  logic [15:0] f1 [IS];

  assign yumi = valid_m[0] & yumi_en;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    pool_layer #(
      .WORD_SIZE(W), .N_SIZE(NS), .N_CHANNELS(NC), .INPUT_SIZE(IS), .MODE(m)
    ) u_dut (
      .clk_i    (clk),
      .reset_n_i(rst_n),
      .valid_i  (valid),
      .ready_o  (ready_m[m]),
      .data_i   (data),
      .valid_o  (valid_m[m]),
      .yumi_i   (yumi),
      .data_o   (dout_m[m])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rand_yumi) yumi_en = 1'($urandom_range(0, 1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: mean of |x|, max of |x| or signed mean, with reciprocal scaling
  function automatic logic [15:0] ref_pool(input int mode, input logic [15:0] xs [IS]);
    longint sum = 0, peak = 0, v, a;
    logic signed [15:0] s;
    for (int i = 0; i < IS; i++) begin
      s = xs[i];
      v = s;
      a = (v < 0) ? -v : v;
      if (a > 32767) a = 32767;
      sum += (mode == 2) ? v : a;
      if (a > peak) peak = a;
    end
    if (mode == 1) return peak[15:0];
    v = (sum * RECIP_M + (longint'(1) <<< (NS - 1))) >>> NS;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] sp [4];
    sp = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  function automatic logic [31:0] exp_mode(input int m);
    return {ref_pool(m, f1), ref_pool(m, f0)};
  endfunction

  // called at a negedge; returns at the negedge after the transfer
  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    if (rand_gap && $urandom_range(0, 2) == 0) begin
      valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b1;
    data  = d;
    while (!ready_m[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_m[0]) check_eq("ready_wait", 32'(ready_m[0]), 32'd1);
    t_xfer = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame();
    logic [95:0] e;
    for (int m = 0; m < 3; m++) e[m*32 +: 32] = exp_mode(m);
    exp_q.push_back(e);
    for (int i = 0; i < IS; i++) send_beat({f1[i], f0[i]});
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_m[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(valid_m[0]), 32'd1);
  endtask

  // output monitor: records valid rises and checks each accepted result
  logic prev_v = 1'b0;
  logic [95:0] mon_e;
  always @(negedge clk) begin
    #1;
    if (valid_m[0] && !prev_v) rise_q.push_back(cyc);
    prev_v = valid_m[0];
    if (valid_m[0] && yumi) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_valid", 32'(valid_m[0]), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        for (int m = 0; m < 3; m++) begin
          check_eq($sformatf("out_mode%0d", m), dout_m[m], mon_e[m*32 +: 32]);
          check_eq($sformatf("valid_mode%0d", m), 32'(valid_m[m]), 32'd1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ta, tb, ty;
    logic [31:0] hold_exp;
    yumi_en = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      check_eq("rst_valid", 32'(valid_m[m]), 32'd0);
      check_eq("rst_data", dout_m[m], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ready_after_rst", 32'(ready_m[0]), 32'd1);

    // abs-average / signed-average cancellation / latency
    f0 = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    f1 = '{16'h1000, 16'hF000, 16'h1000, 16'hF000};
    check_eq("model_s1_m0", exp_mode(0), 32'h1000_1000);
    check_eq("model_s1_m2", exp_mode(2), 32'h0000_1000);
    rise_q.delete();
    send_frame();
    ta = t_xfer;
    wait_drain();
    check_eq("latency", (rise_q.size() > 0) ? 32'(rise_q[0] - ta) : 32'hFFFF_FFFF, 32'd2);

    // abs-max and saturated abs of the most negative code
    f0 = '{16'h0100, 16'hF800, 16'h0200, 16'h0010};
    f1 = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    check_eq("model_s3_m1", exp_mode(1), 32'h7FFF_0800);
    send_frame();
    wait_drain();

    // backpressure in DONE with valid_i held
    yumi_en = 1'b0;
    f0 = '{16'h0123, 16'hFEDC, 16'h7FFF, 16'h0042};
    f1 = '{16'h8000, 16'h0001, 16'h0002, 16'h0003};
    hold_exp = exp_mode(0);
    send_frame();
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      valid = ~BP_READY;
      data  = $urandom;
      @(negedge clk);
      check_eq("bp_data", dout_m[0], hold_exp);
      check_eq("bp_ready", 32'(ready_m[0]), 32'(BP_READY));
      check_eq("bp_valid_hold", 32'(valid_m[0]), 32'd1);
    end
    valid = 1'b0;
    yumi_en = 1'b1;
    wait_drain();
    f0 = '{16'h0800, 16'h0400, 16'hFC00, 16'h0000};
    f1 = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    send_frame();
    wait_drain();

    // reset while a result is presented, then mid-frame
    yumi_en = 1'b0;
    send_frame();
    wait_valid("pre_rst_valid");
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      check_eq("rst_drop_valid", 32'(valid_m[m]), 32'd0);
      check_eq("rst_drop_data", dout_m[m], 32'd0);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    yumi_en = 1'b1;
    send_beat(32'h7FFF_7FFF);
    send_beat(32'h7FFF_7FFF);
    rst_n = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    f0 = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    f1 = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    check_eq("model_s5_m2", exp_mode(2), 32'h0400_0400);
    send_frame();
    wait_drain();

    // back-to-back frames with an always-ready consumer
    f0 = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
    f1 = '{16'hF111, 16'hE222, 16'h0333, 16'h8000};
    rise_q.delete();
    send_frame();
    send_frame();
    wait_drain();
    check_eq("period", (rise_q.size() == 2) ? 32'(rise_q[1] - rise_q[0]) : 32'hFFFF_FFFF,
             32'(PERIOD));

`ifdef POOL_DOUBLE_BUFFER_EN
    // second frame completes while the first is unconsumed
    yumi_en = 1'b0;
    f0 = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    f1 = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    hold_exp = exp_mode(0);
    send_frame();
    f0 = '{16'h0300, 16'h0300, 16'h0300, 16'h0300};
    f1 = '{16'hFD00, 16'h0300, 16'hFD00, 16'h0300};
    send_frame();
    for (int k = 0; k < 3; k++) begin
      check_eq("pend_ready", 32'(ready_m[0]), 32'd0);
      check_eq("pend_valid", 32'(valid_m[0]), 32'd1);
      check_eq("pend_data", dout_m[0], hold_exp);
      @(negedge clk);
    end
    rise_q.delete();
    ty = cyc;
    yumi_en = 1'b1;
    wait_drain();
    check_eq("pend_lat", (rise_q.size() > 0) ? 32'(rise_q[0] - ty) : 32'hFFFF_FFFF, 32'd2);
`endif

    // randomized frames with idle gaps and a random consumer
    rand_gap = 1'b1;
    rand_yumi = 1'b1;
    for (int fr = 0; fr < 12; fr++) begin
      for (int i = 0; i < IS; i++) begin
        f0[i] = rnd_word();
        f1[i] = rnd_word();
      end
      send_frame();
    end
    rand_yumi = 1'b0;
    rand_gap = 1'b0;
    yumi_en = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
